// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter: round-robin pick among enabled pending FIFOs (pndng_i/port_en_i/data_i in, pop_o out) into a one-entry buffer (pndng_o/data_o/grant_o out, popin_i consumes), fwd_cnt_o counts grants
module rr_port_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int PAKG_SIZE = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_PORTS-1:0]             pndng_i,
  input  logic [N_PORTS*PAKG_SIZE-1:0]   data_i,
  output logic [N_PORTS-1:0]             pop_o,
  input  logic [N_PORTS-1:0]             port_en_i,
  output logic                           pndng_o,
  output logic [PAKG_SIZE-1:0]           data_o,
  input  logic                           popin_i,
  output logic [$clog2(N_PORTS)-1:0]     grant_o,
  output logic [15:0]                    fwd_cnt_o
);
  localparam int IW = $clog2(N_PORTS);
  logic [N_PORTS-1:0] w_elig;
  logic               w_any;
  logic               w_grant;
  logic [IW-1:0]      w_sel;
  logic [IW-1:0]      w_cand;
  logic [IW-1:0]      r_ptr;
  assign w_elig = pndng_i & port_en_i;
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_cand = '0;
    for (int o = 1; o <= N_PORTS; o++) begin
      w_cand = IW'((int'(r_ptr) + o) % N_PORTS);
      if (!w_any && w_elig[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end
  assign w_grant = rst_i & (~pndng_o | popin_i) & w_any;
  assign pop_o   = w_grant ? {{(N_PORTS-1){1'b0}}, 1'b1} << w_sel : '0;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pndng_o   <= 1'b0;
      data_o    <= '0;
      grant_o   <= '0;
      r_ptr     <= IW'(N_PORTS - 1);
      fwd_cnt_o <= '0;
    end else if (w_grant) begin
      pndng_o   <= 1'b1;
      data_o    <= data_i[w_sel*PAKG_SIZE +: PAKG_SIZE];
      grant_o   <= w_sel;
      r_ptr     <= w_sel;
      fwd_cnt_o <= fwd_cnt_o + 16'd1;
    end else if (popin_i) begin
      pndng_o   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_port_arbiter.sv
// tb_rr_port_arbiter: randomized and directed scoreboard bench for rr_port_arbiter
module tb_rr_port_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic [N-1:0]   pndng_i = '0;
  logic [N*W-1:0] data_i = '0;
  logic [N-1:0]   pop_o;
  logic [N-1:0]   port_en_i = '1;
  logic           pndng_o;
  logic [W-1:0]   data_o;
  logic           popin_i = 1'b0;
  logic [1:0]     grant_o;
  logic [15:0]    fwd_cnt_o;
  rr_port_arbiter #(.N_PORTS(N), .PAKG_SIZE(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pndng_i(pndng_i), .data_i(data_i), .pop_o(pop_o),
    .port_en_i(port_en_i), .pndng_o(pndng_o), .data_o(data_o), .popin_i(popin_i),
    .grant_o(grant_o), .fwd_cnt_o(fwd_cnt_o));
  always #5 clk_i = ~clk_i;
  typedef struct packed {logic [N-1:0] pop; logic valid; logic [15:0] cnt; logic known;} cyc_t;
  typedef struct packed {logic [W-1:0] data; logic [1:0] idx;} pkt_t;
  cyc_t cq[$];
  pkt_t pq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   m_valid = 1'b0;
  int   m_ptr = N - 1;
  int   m_cnt = 0;
  bit   known = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [N*W-1:0] rnd();
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = $urandom;
    return d;
  endfunction
  task automatic cycle(input logic r, input logic [N-1:0] pnd, input logic [N-1:0] en,
                       input logic pin, input logic [N*W-1:0] d);
    cyc_t c;
    int best;
    int bd;
    @(posedge clk_i);
    #1;
    rst_i = r; pndng_i = pnd; port_en_i = en; popin_i = pin; data_i = d;
    c.pop = '0; c.valid = m_valid; c.cnt = 16'(m_cnt); c.known = known;
    if (!r) begin
      m_valid = 1'b0; m_ptr = N - 1; m_cnt = 0; known = 1'b1;
      pq.delete();
    end else if (!m_valid || pin) begin
      best = -1;
      bd = N;
      for (int k = 0; k < N; k++)
        if (pnd[k] && en[k] && ((k - m_ptr - 1 + N) % N) < bd) begin
          bd = (k - m_ptr - 1 + N) % N;
          best = k;
        end
      if (best >= 0) begin
        c.pop[best] = 1'b1;
        pq.push_back({d[best*W +: W], 2'(best)});
        m_valid = 1'b1; m_ptr = best; m_cnt = (m_cnt + 1) % 65536;
      end else m_valid = 1'b0;
    end
    cq.push_back(c);
    #1;
  endtask
  always @(negedge clk_i) begin
    cyc_t c;
    pkt_t p;
    if (cq.size() > 0) begin
      c = cq.pop_front();
      chk("pop_o", 32'(pop_o), 32'(c.pop));
      if (c.known) begin
        chk("pndng_o", 32'(pndng_o), 32'(c.valid));
        chk("fwd_cnt_o", 32'(fwd_cnt_o), 32'(c.cnt));
      end
      if (rst_i === 1'b1 && popin_i && pndng_o === 1'b1) begin
        if (pq.size() == 0) chk("consume_unexpected", 32'(pndng_o), 32'd0);
        else begin
          p = pq.pop_front();
          chk("data_o", data_o, p.data);
          chk("grant_o", 32'(grant_o), 32'(p.idx));
        end
      end
    end
  end
  initial begin
    logic [N*W-1:0] d;
    cycle(0, '0, '1, 0, '0);
    cycle(0, '0, '1, 0, '0);
    chk("rst_pndng", 32'(pndng_o), 0);
    chk("rst_cnt", 32'(fwd_cnt_o), 0);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_data", data_o, 0);
    for (int i = 0; i <= 8; i++) begin
      cycle(1, 4'hF, 4'hF, 1, rnd());
      if (i > 0) chk("seq_grant", 32'(grant_o), 32'((i - 1) % 4));
    end
    chk("seq_cnt8", 32'(fwd_cnt_o), 8);
    cycle(1, 4'h0, 4'hF, 1, rnd());
    cycle(1, 4'h0, 4'hF, 1, rnd());
    chk("drain_pndng", 32'(pndng_o), 0);
    chk("drain_cnt", 32'(fwd_cnt_o), 9);
    cycle(1, 4'h0, 4'hF, 0, rnd());
    chk("idle_cnt", 32'(fwd_cnt_o), 9);
    d = rnd();
    d[2*W +: W] = 32'hA5A5_0002;
    cycle(1, 4'b0100, 4'hF, 0, d);
    chk("p2_pop", 32'(pop_o), 32'b0100);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 4'b0100, 4'hF, 0, d);
      chk("p2_hold_pop", 32'(pop_o), 0);
      chk("p2_pndng", 32'(pndng_o), 1);
      chk("p2_data", data_o, 32'hA5A5_0002);
      chk("p2_grant", 32'(grant_o), 2);
    end
    cycle(1, 4'h0, 4'hF, 1, d);
    cycle(1, 4'h0, 4'hF, 0, d);
    chk("p2_consumed", 32'(pndng_o), 0);
    cycle(0, 4'hF, 4'hF, 1, rnd());
    chk("rst_pop", 32'(pop_o), 0);
    cycle(1, 4'b0001, 4'hF, 0, rnd());
    for (int j = 0; j <= 4; j++) begin
      cycle(1, 4'b1011, 4'b1110, 1, rnd());
      if (j > 0) chk("mask_grant", 32'(grant_o), (j % 2 == 1) ? 32'd1 : 32'd3);
    end
    cycle(0, 4'hF, 4'hF, 1, rnd());
    chk("midrst_pop", 32'(pop_o), 0);
    cycle(1, 4'hF, 4'hF, 0, rnd());
    chk("midrst_pndng", 32'(pndng_o), 0);
    chk("midrst_cnt", 32'(fwd_cnt_o), 0);
    chk("midrst_pop0", 32'(pop_o), 32'b0001);
    cycle(1, 4'h0, 4'hF, 0, rnd());
    chk("midrst_grant", 32'(grant_o), 0);
    chk("midrst_full", 32'(pndng_o), 1);
    for (int i = 0; i < 400; i++)
      cycle(logic'($urandom_range(0, 39) != 0), 4'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
            logic'($urandom_range(0, 1)), rnd());
    cycle(0, 4'h0, 4'hF, 0, '0);
    for (int i = 0; i < 65536; i++) begin
      cycle(1, 4'hF, 4'hF, 1, rnd());
      if (i == 65535) chk("wrap_pre", 32'(fwd_cnt_o), 65535);
    end
    cycle(1, 4'h0, 4'hF, 0, '0);
    chk("wrap_cnt", 32'(fwd_cnt_o), 0);
    @(negedge clk_i);
    #1;
    chk("sb_drained", 32'(cq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
